// File: rtl/ysyx_23060111_core_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> WAIT -> EXEC per instruction over a
// valid/ready fetch handshake; stops on ebreak, illegal op, bus error or timeout.
module ysyx_23060111_core_mc #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          NR_REGS       = 32,
  parameter int          FETCH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  output logic        ifu_rsp_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        halt,
  output logic        inv_flag,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, retire_pc_q, wait_cnt_q;
  logic        retire_q, inv_q;
  logic [31:0] gpr_q [32];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, imm_j, rs1_val, rs2_val, op_b, alu_res;
  logic [31:0] result, jump_tgt, pc_plus4, next_pc;
  logic        legal, is_ebreak, is_jump, use_rd, use_rs1, use_rs2;
  logic        idx_bad, misalign, exec_ok, wr_en, timeout_hit;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u    = {ir_q[31:12], 12'b0};
  assign imm_j    = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val  = gpr_q[rs1];
  assign rs2_val  = gpr_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  // opcode bit 5 separates register-register ops from op-imm
  assign op_b     = opcode[5] ? rs2_val : imm_i;

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (opcode[5] && ir_q[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu_res = rs1_val << op_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
      3'b011:  alu_res = {31'b0, rs1_val < op_b};
      3'b100:  alu_res = rs1_val ^ op_b;
      3'b101:  alu_res = ir_q[30] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110:  alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    is_jump   = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    result    = '0;
    jump_tgt  = '0;
    case (opcode)
      7'b0110111: begin legal = 1'b1; use_rd = 1'b1; result = imm_u; end
      7'b0010111: begin legal = 1'b1; use_rd = 1'b1; result = pc_q + imm_u; end
      7'b1101111: begin
        legal = 1'b1; use_rd = 1'b1; is_jump = 1'b1;
        result = pc_plus4; jump_tgt = pc_q + imm_j;
      end
      7'b1100111: begin
        legal = (funct3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; is_jump = 1'b1;
        result = pc_plus4; jump_tgt = (rs1_val + imm_i) & ~32'd1;
      end
      7'b0010011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; result = alu_res;
        if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal = 1'b1;
      end
      7'b0110011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; result = alu_res;
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      7'b1110011: begin legal = (ir_q == 32'h0010_0073); is_ebreak = legal; end
      default: ;
    endcase
  end

  assign idx_bad  = (use_rd  && (int'(rd)  >= NR_REGS)) ||
                    (use_rs1 && (int'(rs1) >= NR_REGS)) ||
                    (use_rs2 && (int'(rs2) >= NR_REGS));
  assign misalign = is_jump && jump_tgt[1];
  assign exec_ok  = legal && !idx_bad && !misalign;
  assign wr_en    = (state_q == S_EXEC) && exec_ok && use_rd && (rd != 5'd0);
  assign next_pc  = is_jump ? jump_tgt : pc_plus4;
  assign timeout_hit = (FETCH_TIMEOUT > 0) && (wait_cnt_q == 32'(FETCH_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (ifu_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (ifu_rsp_valid)    state_d = ifu_rsp_err ? S_HALT : S_EXEC;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_EXEC:  state_d = (exec_ok && !is_ebreak) ? S_FETCH : S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      wait_cnt_q  <= '0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      inv_q       <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: wait_cnt_q <= '0;
        S_WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) inv_q <= 1'b1;
            else             ir_q  <= ifu_rsp_data;
          end else if (timeout_hit) begin
            inv_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        S_EXEC: begin
          if (exec_ok) begin
            retire_q    <= 1'b1;
            retire_pc_q <= pc_q;
            if (!is_ebreak) pc_q <= next_pc;
          end else begin
            inv_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entries 0 and >= NR_REGS are never written, so they always read back 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (wr_en) begin
      gpr_q[rd] <= result;
    end
  end

  assign ifu_req_valid = (state_q == S_FETCH);
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = (state_q == S_WAIT);
  assign pc            = pc_q;
  assign retire        = retire_q;
  assign retire_pc     = retire_pc_q;
  assign halt          = (state_q == S_HALT);
  assign inv_flag      = inv_q;
  assign dbg_rdata     = gpr_q[dbg_raddr];

endmodule

// File: tb/tb_ysyx_23060111_core_mc.sv
// Directed bench: instance A uses default parameters, instance B uses
// NR_REGS=16 / FETCH_TIMEOUT=4; sel routes the shared memory stimulus.
module tb_ysyx_23060111_core_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [4:0]  dbg_raddr = '0;

  logic        a_req_valid, a_rsp_ready, a_retire, a_halt, a_inv;
  logic [31:0] a_req_addr, a_pc, a_retire_pc, a_dbg;
  logic        b_req_valid, b_rsp_ready, b_retire, b_halt, b_inv;
  logic [31:0] b_req_addr, b_pc, b_retire_pc, b_dbg;

  logic a_ready_in, a_valid_in, b_ready_in, b_valid_in;
  assign a_ready_in = req_ready & ~sel;
  assign a_valid_in = rsp_valid & ~sel;
  assign b_ready_in = req_ready & sel;
  assign b_valid_in = rsp_valid & sel;

  ysyx_23060111_core_mc dut_a (
    .clk(clk), .rst(rst),
    .ifu_req_valid(a_req_valid), .ifu_req_addr(a_req_addr), .ifu_req_ready(a_ready_in),
    .ifu_rsp_valid(a_valid_in), .ifu_rsp_data(rsp_data), .ifu_rsp_err(rsp_err),
    .ifu_rsp_ready(a_rsp_ready), .pc(a_pc), .retire(a_retire), .retire_pc(a_retire_pc),
    .halt(a_halt), .inv_flag(a_inv), .dbg_raddr(dbg_raddr), .dbg_rdata(a_dbg)
  );

  ysyx_23060111_core_mc #(.NR_REGS(16), .FETCH_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(b_req_valid), .ifu_req_addr(b_req_addr), .ifu_req_ready(b_ready_in),
    .ifu_rsp_valid(b_valid_in), .ifu_rsp_data(rsp_data), .ifu_rsp_err(rsp_err),
    .ifu_rsp_ready(b_rsp_ready), .pc(b_pc), .retire(b_retire), .retire_pc(b_retire_pc),
    .halt(b_halt), .inv_flag(b_inv), .dbg_raddr(dbg_raddr), .dbg_rdata(b_dbg)
  );

  logic        obs_req_valid, obs_rsp_ready, obs_retire, obs_halt, obs_inv;
  logic [31:0] obs_req_addr, obs_pc, obs_retire_pc, obs_dbg;
  assign obs_req_valid = sel ? b_req_valid : a_req_valid;
  assign obs_rsp_ready = sel ? b_rsp_ready : a_rsp_ready;
  assign obs_retire    = sel ? b_retire    : a_retire;
  assign obs_halt      = sel ? b_halt      : a_halt;
  assign obs_inv       = sel ? b_inv       : a_inv;
  assign obs_req_addr  = sel ? b_req_addr  : a_req_addr;
  assign obs_pc        = sel ? b_pc        : a_pc;
  assign obs_retire_pc = sel ? b_retire_pc : a_retire_pc;
  assign obs_dbg       = sel ? b_dbg       : a_dbg;

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          ret_cnt = 0;
  logic [31:0] last_rpc = '0;

  always @(negedge clk) begin
    if (obs_retire === 1'b1) begin
      ret_cnt  <= ret_cnt + 1;
      last_rpc <= obs_retire_pc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    chk(tag, obs_dbg, exp);
  endtask

  task automatic do_reset(input logic s);
    sel = s; rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Full fetch/exec of one word; ends 1 time unit after the negedge following EXEC.
  task automatic run_instr(input logic [31:0] word, input int rdy_dly,
                           input int rsp_dly, input logic err);
    logic [31:0] addr0;
    logic        stable;
    for (int i = 0; i < 20 && obs_req_valid !== 1'b1; i++) @(negedge clk);
    chk("req_valid", {31'b0, obs_req_valid}, 32'd1);
    addr0  = obs_req_addr;
    stable = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      if (obs_req_addr !== addr0 || obs_req_valid !== 1'b1) stable = 1'b0;
    end
    if (rdy_dly > 0) chk("req_stable", {31'b0, stable}, 32'd1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) @(negedge clk);
    chk("rsp_ready", {31'b0, obs_rsp_ready}, 32'd1);
    rsp_valid = 1'b1; rsp_data = word; rsp_err = err;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;

    do_reset(1'b0);
    chk("rst_pc", obs_pc, 32'h8000_0000);
    chk("rst_req_addr", obs_req_addr, 32'h8000_0000);
    chk("rst_halt", {31'b0, obs_halt}, 32'd0);
    chk("rst_inv", {31'b0, obs_inv}, 32'd0);
    chk("rst_retire", {31'b0, obs_retire}, 32'd0);
    chk_reg("rst_x1", 5'd1, 32'd0);

    r0 = ret_cnt;
    run_instr(32'h0050_0093, 0, 0, 1'b0);                  // addi x1,x0,5
    chk("addi_retire", ret_cnt - r0, 32'd1);
    chk("addi_rpc", last_rpc, 32'h8000_0000);
    chk_reg("addi_x1", 5'd1, 32'd5);
    chk("addi_pc", obs_pc, 32'h8000_0004);

    run_instr(32'h0010_8133, 0, 0, 1'b0);                  // add x2,x1,x1
    chk_reg("add_x2", 5'd2, 32'd10);
    run_instr(32'h1234_51B7, 0, 0, 1'b0);                  // lui x3,0x12345
    chk_reg("lui_x3", 5'd3, 32'h1234_5000);
    run_instr(32'h0080_00EF, 0, 0, 1'b0);                  // jal x1,+8 @0x8000000C
    chk_reg("jal_x1", 5'd1, 32'h8000_0010);
    chk("jal_next", obs_req_addr, 32'h8000_0014);
    run_instr(32'hFFF0_0213, 0, 0, 1'b0);                  // addi x4,x0,-1
    chk_reg("addi_x4", 5'd4, 32'hFFFF_FFFF);
    run_instr(32'h0002_2293, 0, 0, 1'b0);                  // slti x5,x4,0
    chk_reg("slti_x5", 5'd5, 32'd1);
    run_instr(32'h0000_8067, 0, 0, 1'b0);                  // jalr x0,0(x1)
    chk("jalr_next", obs_req_addr, 32'h8000_0010);
    chk_reg("x0_zero", 5'd0, 32'd0);

    r0 = ret_cnt;
    run_instr(32'h4022_0333, 5, 7, 1'b0);                  // sub x6,x4,x2 with stalls
    chk("stall_retires", ret_cnt - r0, 32'd1);
    chk_reg("sub_x6", 5'd6, 32'hFFFF_FFF5);
    chk("stall_halt", {31'b0, obs_halt}, 32'd0);
    run_instr(32'h01C2_5493, 0, 0, 1'b0);                  // srli x9,x4,28
    chk_reg("srli_x9", 5'd9, 32'h0000_000F);
    run_instr(32'h4042_5413, 0, 0, 1'b0);                  // srai x8,x4,4
    chk_reg("srai_x8", 5'd8, 32'hFFFF_FFFF);

    r0 = ret_cnt;
    run_instr(32'h0010_0073, 0, 0, 1'b0);                  // ebreak @0x8000001C
    chk("ebrk_retire", ret_cnt - r0, 32'd1);
    chk("ebrk_rpc", last_rpc, 32'h8000_001C);
    chk("ebrk_pc", obs_pc, 32'h8000_001C);
    chk("ebrk_halt", {31'b0, obs_halt}, 32'd1);
    chk("ebrk_inv", {31'b0, obs_inv}, 32'd0);
    r0 = ret_cnt;
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    repeat (3) @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("halt_sticky", {31'b0, obs_halt}, 32'd1);
    chk("halt_reqv", {31'b0, obs_req_valid}, 32'd0);
    chk("halt_rspr", {31'b0, obs_rsp_ready}, 32'd0);
    chk("halt_noret", ret_cnt - r0, 32'd0);
    chk("halt_pc", obs_pc, 32'h8000_001C);

    do_reset(1'b0);
    r0 = ret_cnt;
    run_instr(32'h0000_0000, 0, 0, 1'b0);
    chk("ill0_halt", {31'b0, obs_halt}, 32'd1);
    chk("ill0_inv", {31'b0, obs_inv}, 32'd1);
    chk("ill0_noret", ret_cnt - r0, 32'd0);
    chk("ill0_pc", obs_pc, 32'h8000_0000);

    do_reset(1'b0);
    r0 = ret_cnt;
    run_instr(32'h0050_0093, 0, 0, 1'b1);                  // bus error
    chk("err_halt", {31'b0, obs_halt}, 32'd1);
    chk("err_inv", {31'b0, obs_inv}, 32'd1);
    chk("err_noret", ret_cnt - r0, 32'd0);
    chk_reg("err_x1", 5'd1, 32'd0);

    do_reset(1'b0);
    r0 = ret_cnt;
    run_instr(32'h0020_00EF, 0, 0, 1'b0);                  // jal x1,+2: misaligned
    chk("mis_inv", {31'b0, obs_inv}, 32'd1);
    chk("mis_noret", ret_cnt - r0, 32'd0);
    chk("mis_pc", obs_pc, 32'h8000_0000);
    chk_reg("mis_x1", 5'd1, 32'd0);

    do_reset(1'b0);
    run_instr(32'h0050_0093, 0, 0, 1'b0);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("pre_wait", {31'b0, obs_rsp_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    r0 = ret_cnt;
    rsp_valid = 1'b1; rsp_data = 32'h0070_0093;
    @(negedge clk);
    rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_pc", obs_pc, 32'h8000_0000);
    chk_reg("rw_x1", 5'd1, 32'd0);
    chk("rw_noret", ret_cnt - r0, 32'd0);
    chk("rw_reqv", {31'b0, obs_req_valid}, 32'd1);
    chk("rw_addr", obs_req_addr, 32'h8000_0000);
    run_instr(32'h0030_0113, 0, 0, 1'b0);                  // addi x2,x0,3
    chk_reg("rw_x2", 5'd2, 32'd3);
    chk("rw_rpc", last_rpc, 32'h8000_0000);

    do_reset(1'b1);
    run_instr(32'h0050_0793, 0, 0, 1'b0);                  // addi x15,x0,5
    chk_reg("e_x15", 5'd15, 32'd5);
    chk_reg("e_x16_rd", 5'd16, 32'd0);

    do_reset(1'b1);
    r0 = ret_cnt;
    run_instr(32'h0050_0813, 0, 0, 1'b0);                  // addi x16 on RV32E
    chk("e_x16_halt", {31'b0, obs_halt}, 32'd1);
    chk("e_x16_inv", {31'b0, obs_inv}, 32'd1);
    chk("e_x16_noret", ret_cnt - r0, 32'd0);
    chk("e_x16_pc", obs_pc, 32'h8000_0000);

    do_reset(1'b1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("to_3cyc_halt", {31'b0, obs_halt}, 32'd0);
    @(negedge clk);
    #1;
    chk("to_4cyc_halt", {31'b0, obs_halt}, 32'd1);
    chk("to_inv", {31'b0, obs_inv}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ysyx_23060111_core_mc.md
Name: ysyx_23060111_core_mc

Overview:
Multi-cycle RV32I-subset core, the successor to the single-cycle top.
- Instruction fetch goes through a valid/ready request/response handshake, so memory latency is arbitrary.
- Register count, reset PC and fetch timeout are parametrised.
- Stops on ebreak or on an illegal instruction, fetch error or timeout, and reports which.
- Sits between the simulation harness or memory model and the (future) LSU.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- NR_REGS, 32, number of GPRs: 32 (RV32I) or 16 (RV32E). Any register index >= NR_REGS is illegal.
- FETCH_TIMEOUT, 0, maximum cycles spent in WAIT for a response. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_addr  out  32  fetch address, equal to pc.
- ifu_req_ready  in  1  memory accepts the request.
- ifu_rsp_valid  in  1  instruction word valid.
- ifu_rsp_data  in  32  instruction word.
- ifu_rsp_err  in  1  bus error, qualified by ifu_rsp_valid.
- ifu_rsp_ready  out  1  core accepts the response.
- pc  out  32  current PC.
- retire  out  1  one-cycle pulse when an instruction commits.
- retire_pc  out  32  PC of the committed instruction, valid while retire=1.
- halt  out  1  sticky; core stopped.
- inv_flag  out  1  sticky; stop caused by an illegal instruction, misaligned target, bus error or timeout.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  32  combinational read of GPR[dbg_raddr]; returns 0 for index 0 or index >= NR_REGS.

Behaviour:
Reset (rst=0 at a rising edge):
- pc=RESET_PC, all GPRs=0, state=FETCH, halt=0, inv_flag=0, retire=0.
- Reset has priority over every other event. It aborts any in-flight handshake; a response arriving after reset is ignored until a new request has been accepted.

FSM states: FETCH, WAIT, EXEC, HALT.
- FETCH:
  - ifu_req_valid=1 and ifu_req_addr=pc, held stable until ifu_req_ready=1.
  - On the req_valid & req_ready edge, go to WAIT.
- WAIT:
  - ifu_rsp_ready=1.
  - On rsp_valid & !err: latch the instruction, go to EXEC.
  - On rsp_valid & err: go to HALT with inv_flag=1.
  - If FETCH_TIMEOUT>0 and the wait counter reaches FETCH_TIMEOUT with no response: go to HALT with inv_flag=1. The counter clears on entry to WAIT.
- EXEC (exactly one cycle):
  - Decode, write rd, update pc.
  - retire=1 and retire_pc=old pc on the cycle after EXEC (registered). Then go to FETCH.
- HALT:
  - Absorbing; only reset leaves it.
  - Drives req_valid=0, rsp_ready=0, retire=0.

Minimum latency: 3 cycles per instruction when ready and response are immediate.

Supported instructions (all others, including opcode 0 and all-ones, are illegal):
- lui, auipc, jal, jalr (funct3=0).
- op-imm: addi, slti, sltiu, xori, ori, andi, slli, srli, srai. Shift funct7 must be 0 (or 0x20 for srai).
- op: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
- ebreak (0x00100073).

Arithmetic rules:
- 32-bit two's complement; results wrap modulo 2^32.
- Immediates are sign-extended.
- Shift amount is bits [4:0].
- slt is signed; sltu is unsigned.

Register rules:
- Writes to x0 are discarded; x0 always reads 0.
- A rs1, rs2 or rd index >= NR_REGS in a used field makes the instruction illegal.

Control-flow rules:
- jal/jalr write pc+4 to rd.
- jalr target = (rs1+imm) & ~1. When rd==rs1, the target uses the old rs1 value.
- A jal/jalr target with bit1=1 is misaligned. It causes an illegal halt: no rd write and no pc update.
- Non-jump instructions: pc += 4, wrapping at 2^32.

Halt rules:
- Illegal instruction: no GPR write, pc holds the offending address, retire stays 0, halt=1, inv_flag=1.
- ebreak: retire pulses, pc holds the ebreak address, halt=1, inv_flag=0.

Test Plan:
- Reset, then a memory that answers in 0 cycles with 0x00500093 (addi x1,x0,5). Required: ifu_req_addr=0x80000000; retire pulses with retire_pc=0x80000000; dbg x1=5; pc=0x80000004.
- Sequence 0x00108133 (add x2,x1,x1), 0x123451B7 (lui x3,0x12345), 0xFFF00213 (addi x4,x0,-1). Required: x2=10, x3=0x12345000, x4=0xFFFFFFFF. Then 0x00022293 (slti x5,x4,0) gives x5=1.
- 0x008000EF (jal x1,+8) at 0x8000000C. Required: x1=0x80000010, next ifu_req_addr=0x80000014. Then 0x00008067 (jalr x0,0(x1)): next fetch at 0x80000010.
- ifu_req_ready held low 5 cycles, then rsp_valid delayed 7 cycles. Required: req_addr stable throughout; exactly one retire. With FETCH_TIMEOUT=4: halt=1 and inv_flag=1 after 4 WAIT cycles.
- Illegal cases: 0x00000000 gives halt=1, inv_flag=1, no retire, pc unchanged. ifu_rsp_err=1 gives the same. With NR_REGS=16, 0x00500813 (addi x16) is illegal. 0x00100073 gives retire=1, halt=1, inv_flag=0.
- Assert rst=0 while in WAIT, with a stale response arriving next cycle. Required: pc=0x80000000, GPRs=0, the stale response is ignored, and a fresh request is issued.
